// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the CPU data bus.
// Written bytes are queued in a FIFO and sent as 8N1 frames on tx.
// The bit period is set by a programmable divider.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit,
// giving 8E1 frames. STATUS bit4 reports that the option is present.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for DIV cycles
// DATA   | 8 data bits, LSB first, DIV cycles each
// PARITY | even parity bit, DIV cycles (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); chains straight into the next START if queued
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PAR_BIT  = 1'b1;
`else
    localparam logic       PAR_BIT  = 1'b0;
`endif

    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   div_lat_q, div_lat_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic        in_win;
    logic [1:0]  reg_off;
    logic        push_req, push_acc, pop, load;
    logic        fifo_empty, fifo_full;
    logic        ovf_clr;
    logic        div_wr;
    logic [15:0] div_wr_val;
    logic [7:0]  head_byte;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{daddr[1:0], dwdata[31:16], dwe[3:2]};

    assign in_win     = (daddr[31:4] == BASE_ADDR[31:4]);
    assign reg_off    = daddr[3:2];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign head_byte  = mem_q[rd_ptr_q];

    assign push_req = in_win && (reg_off == 2'd0) && dwe[0];
    assign push_acc = push_req && (!fifo_full || pop);
    assign ovf_clr  = in_win && (reg_off == 2'd1) && dwe[0] && dwdata[3];
    assign div_wr   = in_win && (reg_off == 2'd2) && (|dwe[1:0]);
    assign div_wr_val = {dwe[1] ? dwdata[15:8] : div_q[15:8],
                         dwe[0] ? dwdata[7:0]  : div_q[7:0]};

    // FIFO bookkeeping, sticky overflow and divider register
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_acc && !pop)      count_d = count_q + (PW+1)'(1);
        else if (!push_acc && pop) count_d = count_q - (PW+1)'(1);
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;
        else if (ovf_clr)                  ovf_d = 1'b0;
        if (div_wr) div_d = (div_wr_val == 16'd0) ? 16'd1 : div_wr_val;
    end

    // Frame sequencer; each state holds for the divider latched at pop
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DATA;
                    cnt_d   = div_lat_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_lat_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_STOP;
                    cnt_d   = div_lat_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d   = S_START;
            shift_d   = head_byte;
            div_lat_d = div_q;
            cnt_d     = div_q - 16'd1;
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            par_d     = ^head_byte;
`endif
        end
    end

    assign pop = load;

    // Registered line level derived from the next state, so tx never glitches
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset; a reset abandons any frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            div_q     <= DEFAULT_DIV;
            div_lat_q <= DEFAULT_DIV;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care until pointed at, so no reset
    always_ff @(posedge clk) begin
        if (push_acc && !reset) mem_q[wr_ptr_q] <= dwdata[7:0];
    end

    assign status = {20'd0, 4'(count_q), 3'd0, PAR_BIT, ovf_q,
                     fifo_empty, fifo_full, (state_q != S_IDLE)};

    // Zero-latency read mux; zero outside the window so it can be ORed with dmem
    always_comb begin
        drdata = 32'd0;
        if (in_win) begin
            case (reg_off)
                2'd1:    drdata = status;
                2'd2:    drdata = {16'd0, div_q};
                default: drdata = 32'd0;
            endcase
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef UART_TX_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;
    logic        tx;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd4)) dut (
        .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata),
        .dwe(dwe), .drdata(drdata), .tx(tx)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic busy, input logic full, input logic empty,
                                       input logic ovf, input int cnt);
        return PB | (32'(cnt) << 8) | {28'd0, ovf, empty, full, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        daddr  = a;
        dwdata = d;
        dwe    = be;
        tick();
        dwe = 4'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        daddr = a;
        #1;
        chk_eq(tag, drdata, exp);
    endtask

    // Entered just after the pop edge; returns just after the edge ending the frame.
    task automatic chk_frame(input logic [7:0] b, input int div, input logic wr_mid,
                             input logic [15:0] wr_val);
        logic [10:0] fr;
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
`else
        fr = {2'b11, b, 1'b0};
`endif
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < div; k++) begin
                if (wr_mid && i == 5 && k == 0) begin
                    daddr  = BASE + 32'h8;
                    dwdata = {16'h0, wr_val};
                    dwe    = 4'b0011;
                end
                if (i == NB - 1 && k == div - 1) begin
                    daddr = BASE + 32'h4;
                    #1;
                    chk_eq($sformatf("busy last stop %02h", b), {31'd0, drdata[0]}, 32'd1);
                end
                chk_eq($sformatf("tx byte %02h bit %0d cyc %0d", b, i, k), {31'd0, tx}, {31'd0, fr[i]});
                tick();
                dwe = 4'b0;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic       saw_low;
        daddr  = BASE + 32'h4;
        dwdata = 32'd0;
        dwe    = 4'b0;
        reset  = 1'b1;
        repeat (3) tick();
        chk_eq("tx in reset", {31'd0, tx}, 32'd1);
        rd("status reset", BASE + 32'h4, st(0, 0, 1, 0, 0));
        rd("div reset", BASE + 32'h8, 32'd4);
        rd("txdata reads 0", BASE, 32'd0);
        rd("reserved reads 0", BASE + 32'hC, 32'd0);
        reset = 1'b0;
        tick();

        // 0x55 at DIV=4, upper lanes of store data ignored
        wr(BASE, 32'hABCD_1255, 4'b0001);
        rd("status after push", BASE + 32'h4, st(0, 0, 0, 0, 1));
        chk_eq("tx before pop", {31'd0, tx}, 32'd1);
        tick();
        chk_frame(8'h55, 4, 1'b0, 16'h0);
        rd("idle after 0x55", BASE + 32'h4, st(0, 0, 1, 0, 0));
        wr(BASE, 32'h77, 4'b0010);
        rd("lane1 no push", BASE + 32'h4, st(0, 0, 1, 0, 0));

        // divider writes
        wr(BASE + 32'h8, 32'h0, 4'b0011);
        rd("div 0 stored as 1", BASE + 32'h8, 32'd1);
        wr(BASE + 32'h8, 32'h1234, 4'b0001);
        rd("div low lane only", BASE + 32'h8, 32'h34);
        wr(BASE + 32'hB, 32'h0, 4'b0011);
        rd("div 0 via unaligned addr", BASE + 32'h8, 32'd1);
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
        rd("reserved write ignored div", BASE + 32'h8, 32'd1);
        rd("reserved write no push", BASE + 32'h4, st(0, 0, 1, 0, 0));
        wr(BASE, 32'hA3, 4'b0001);
        tick();
        chk_frame(8'hA3, 1, 1'b0, 16'h0);
        rd("idle after 0xA3", BASE + 32'h4, st(0, 0, 1, 0, 0));
        wr(BASE + 32'h8, 32'h4, 4'b0011);

        // fill, overflow, clear, push+pop while full
        wr(BASE, 32'h00, 4'b0001);
        for (int i = 1; i <= 8; i++) wr(BASE, 32'(i), 4'b0001);
        rd("status full", BASE + 32'h4, st(1, 1, 0, 0, 8));
        wr(BASE, 32'h09, 4'b0001);
        rd("overflow set", BASE + 32'h4, st(1, 1, 0, 1, 8));
        wr(BASE + 32'h4, 32'h7, 4'b0001);
        rd("overflow kept", BASE + 32'h4, st(1, 1, 0, 1, 8));
        wr(BASE + 32'h4, 32'h8, 4'b0001);
        rd("overflow cleared", BASE + 32'h4, st(1, 1, 0, 0, 8));
        repeat (29) tick();
        wr(BASE, 32'h0A, 4'b0001);
        rd("push+pop while full", BASE + 32'h4, st(1, 1, 0, 0, 8));
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        foreach (q[i]) chk_frame(q[i], 4, 1'b0, 16'h0);
        rd("idle after burst", BASE + 32'h4, st(0, 0, 1, 0, 0));

        // DIV change mid-frame applies to the next frame only
        wr(BASE, 32'h0F, 4'b0001);
        wr(BASE, 32'hF0, 4'b0001);
        chk_frame(8'h0F, 4, 1'b1, 16'd8);
        chk_frame(8'hF0, 8, 1'b0, 16'h0);
        rd("idle after div change", BASE + 32'h4, st(0, 0, 1, 0, 0));
        rd("div now 8", BASE + 32'h8, 32'd8);
        wr(BASE + 32'h8, 32'h6, 4'b0011);

        // reset in the middle of a frame
        wr(BASE, 32'h00, 4'b0001);
        wr(BASE, 32'h11, 4'b0001);
        wr(BASE, 32'h22, 4'b0001);
        repeat (13) tick();
        chk_eq("tx low mid frame", {31'd0, tx}, 32'd0);
        rd("status before reset", BASE + 32'h4, st(1, 0, 0, 0, 2));
        reset = 1'b1;
        tick();
        chk_eq("tx after reset", {31'd0, tx}, 32'd1);
        rd("status after reset", BASE + 32'h4, st(0, 0, 1, 0, 0));
        rd("div after reset", BASE + 32'h8, 32'd4);
        reset   = 1'b0;
        saw_low = 1'b0;
        repeat (80) begin
            tick();
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk_eq("no frame after reset", {31'd0, saw_low}, 32'd0);

        // address window
        wr(32'h0000_1000, 32'h99, 4'b0001);
        rd("outside write no push", BASE + 32'h4, st(0, 0, 1, 0, 0));
        wr(BASE + 32'h10, 32'h99, 4'b0001);
        rd("above window no push", BASE + 32'h4, st(0, 0, 1, 0, 0));
        wr(BASE, 32'h07, 4'b0001);
        rd("read 0x1000", 32'h0000_1000, 32'd0);
        rd("read 0x1004", 32'h0000_1004, 32'd0);
        rd("read above window", BASE + 32'h14, 32'd0);
        rd("status low addr bits", BASE + 32'h7, st(0, 0, 0, 0, 1));
        tick();
        chk_frame(8'h07, 4, 1'b0, 16'h0);
        rd("idle at end", BASE + 32'h4, st(0, 0, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus (`daddr`/`dwdata`/`dwe`/`drdata`), downstream of the single-cycle CPU alongside `dmem`. Stores written bytes in a small FIFO and serialises them as 8N1 frames on `tx`, with a programmable bit-period divider. Read data is combinational, so the single-cycle load path is unchanged. `drdata` is zero outside the block's window, so the top level ORs it with the `dmem` read data.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_2000: word-aligned base of the 16-byte register window.
- `FIFO_DEPTH`, 8: power of two, at least 2.
- `DEFAULT_DIV`, 4: reset value of the bit-period divider, in clock cycles per bit.

Ports:
- `clk`, input, 1: the only clock. All state updates on `posedge clk`.
- `reset`, input, 1: synchronous, active-high.
- `daddr`, input, 32: CPU data address.
- `dwdata`, input, 32: CPU store data.
- `dwe`, input, 4: byte write enables; bit 0 is lane [7:0].
- `drdata`, output, 32: combinational read data; 0 when `daddr` is outside `BASE_ADDR`..`BASE_ADDR+15`.
- `tx`, output, 1: serial line; idle high.

## Operation
Register map (`daddr[3:2]`); `daddr[1:0]` is ignored.
- Offset 0x0, TXDATA (write-only, reads 0): `dwe[0]=1` pushes `dwdata[7:0]`. Other lanes are ignored.
- Offset 0x4, STATUS (read):
  - bit0 busy: a frame is in progress.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow: sticky.
  - bits[11:8] FIFO count.
  - Other bits 0.
  - A write with `dwe[0]=1` and `dwdata[3]=1` clears overflow.
- Offset 0x8, DIV (read/write, bits [15:0]): written via `dwe[1:0]`. A written value of 0 is stored as 1.
- Offset 0xC: reserved; reads 0, writes ignored.

FIFO:
- Push when full with no same-cycle pop: byte dropped, overflow set.
- Push and pop in the same cycle while full: push accepted, count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

FSM states IDLE, START, DATA, STOP:
- IDLE: `tx=1`. If the FIFO is non-empty, pop into the shift register, latch DIV into the bit counter reload, and go to START.
- START: `tx=0` for DIV cycles, then DATA.
- DATA: 8 bits LSB first, each held DIV cycles. The bit index counts 0..7, then STOP.
- STOP: `tx=1` for DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.

DIV written mid-frame affects only the next frame, because it is latched at pop.

Reset values: `tx=1`, FSM IDLE, FIFO empty (count 0), overflow 0, DIV=`DEFAULT_DIV`. `drdata` follows the reset state combinationally.

Reset mid-frame: on the next edge, `tx=1`, the frame is abandoned, and FIFO contents are discarded.

## Timing
- Push at edge N into an empty FIFO with the FSM idle:
  - Pop at edge N+1; `tx` falls after edge N+1.
  - STATUS shows count 1 and busy 0 between N and N+1.
- Each bit lasts exactly the latched DIV cycles. A frame is 10×DIV cycles (11×DIV with parity).
- Back-to-back bytes: the next start bit begins on the cycle after the last stop-bit cycle.
- busy is 1 from the pop edge through the last stop cycle of the final frame.
- `drdata` has zero latency, combinational from `daddr` and current state.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP that drives even parity (XOR of the 8 data bits) for DIV cycles.
  - Frame is 11×DIV cycles.
  - STATUS bit4 reads 1.
- `UART_TX_PARITY_EN` not defined: 8N1 only, no PARITY state, STATUS bit4 reads 0.

## Test plan
- Reset, then store 0x55 to BASE_ADDR with DIV=4 -> `tx` is 1 during reset. `tx` low for 4 cycles starting the edge after the store, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high. busy clears 40 cycles after the pop.
- Write DIV=0 -> reading 0x8 returns 1. A store of 0xA3 produces a 10-cycle frame.
- With `tx` busy, store 9 bytes (0x00..0x08) with DEPTH=8 -> count reaches 8 and full=1. The 9th byte is dropped only if no pop coincides, and overflow=1. Writing STATUS with `dwdata`=0x8 clears overflow. All accepted bytes appear in order with no inter-frame idle gap.
- Write DIV=8 in the middle of frame 0x0F, with 0xF0 queued -> 0x0F finishes at 4 cycles/bit and 0xF0 uses 8 cycles/bit.
- Assert `reset` at cycle 15 of a frame with 3 bytes queued -> `tx`=1 the next edge, STATUS reads 0x4 (empty), and no further frames are sent.
- `UART_TX_PARITY_EN` defined, store 0x07 -> after the 8 data bits, the parity bit is 1 for DIV cycles, then stop, and STATUS bit4=1. A read of `daddr`=0x1000 returns 0.
